cbus_rr_arbiter: RTL

Parametrised N-master arbiter for the simplified burst cache bus (cbus_req_t / cbus_resp_t). It sits between the per-cache cbus masters (icache, dcache, page-table walker, uncached path) and the single cbus toward the AXI bridge. It generalises the fixed two-master arbiter in three ways: arbitrary master count, a selectable round-robin or fixed-priority policy, and a beat counter that checks each burst's length against `last`.

---
 rtl/cbus_rr_arbiter_pkg.sv | 37 +++
 rtl/cbus_rr_arbiter_pick.sv | 37 +++
 rtl/cbus_rr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus types: request/response bundles,
// burst length encoding and bus-wide limits.
package common;

  localparam int CBUS_MAX_BEATS   = 256;
  localparam int CBUS_MAX_MASTERS = 16;

  // Burst length, encoded as beats-1.
  typedef enum logic [7:0] {
    MLEN1   = 8'd0,
    MLEN2   = 8'd1,
    MLEN4   = 8'd3,
    MLEN8   = 8'd7,
    MLEN16  = 8'd15,
    MLEN32  = 8'd31,
    MLEN64  = 8'd63,
    MLEN128 = 8'd127,
    MLEN256 = 8'd255
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef cbus_req_t cbus_req_vec_t [CBUS_MAX_MASTERS];

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// Combinational winner selection: rotate the valid
// vector by the pointer, then priority-encode.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter bit RR_MODE     = 1'b1,
  localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] valid,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any
);

  localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MASTERS);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         off;
  logic [IDX_W:0]           sum;

  // Fixed priority is a rotation by zero.
  always_comb begin
    ptr = RR_MODE ? rr_ptr : '0;
    dbl = {valid, valid};
    rot = NUM_MASTERS'(dbl >> ptr);
    off = '0;
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NM) winner = IDX_W'(sum - NM);
    else           winner = sum[IDX_W-1:0];
    any = |valid;
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-master cbus arbiter: round-robin or fixed
// priority, whole-burst grants, burst length check.
module cbus_rr_arbiter
  import common::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter bit RR_MODE     = 1'b1,
  localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_MASTERS],
  output cbus_resp_t       iresps [NUM_MASTERS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             beat_err
);

  localparam int BCNT_W = $clog2(CBUS_MAX_BEATS) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_MASTERS-1);

  logic [0:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [BCNT_W-1:0]      beat_cnt;
  logic [7:0]             len_q;
  logic [NUM_MASTERS-1:0] vld;
  logic [IDX_W-1:0]       win;
  logic                   any;
  logic                   done;
  logic                   len_hit;
  logic                   len_bad;
  logic [IDX_W-1:0]       nxt_ptr;

  // Gather the request valids for the picker.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      vld[i] = ireqs[i].valid;
    end
  end

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .RR_MODE    (RR_MODE)
  ) u_pick (
    .valid (vld),
    .rr_ptr(rr_ptr),
    .winner(win),
    .any   (any)
  );

  // Completion, length check and pointer advance.
  always_comb begin
    done    = oresp.ready && oresp.last;
    len_hit = (beat_cnt == BCNT_W'(len_q));
    len_bad = oresp.ready && (oresp.last != len_hit);
    nxt_ptr = (grant_idx == LAST_IDX) ? '0
                                      : grant_idx + 1'b1;
  end

  // Grant FSM, beat counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      beat_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            grant_idx <= win;
            len_q     <= ireqs[win].len;
            beat_cnt  <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (oresp.ready) beat_cnt <= beat_cnt + 1'b1;
          if (len_bad)     beat_err <= 1'b1;
          if (done) begin
            state  <= S_IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Route the owner's request out and the response back.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      iresps[i] = '0;
    end
    if (state == S_BUSY) begin
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

  assign busy = (state == S_BUSY);

endmodule
